mesi_isc_fifo_bcast_reader: RTL and testbench

- Consumer end of a mesi_isc basic FIFO.
- Pops entries through the FIFO's read interface (empty flag, registered data_o, rd_i) into a 2-entry internal buffer.
- Broadcasts the head entry to CPU_COUNT targets, each over its own valid/ready handshake.
- Retires the head only after every target has accepted it.
- Sits between the snoop request FIFOs and the per-CPU broadcast ports.

---
 rtl/mesi_isc_fifo_bcast_reader.sv | 119 +++++++++++
 tb/tb_mesi_isc_fifo_bcast_reader.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_isc_fifo_bcast_reader.sv
// Consumer end of a mesi_isc basic FIFO: pops into a 2-entry buffer and
// broadcasts the head to CPU_COUNT targets, retiring it once all accepted.
module mesi_isc_fifo_bcast_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CPU_COUNT  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
  output logic [CPU_COUNT-1:0]  bc_valid_o,
  input  logic [CPU_COUNT-1:0]  bc_ready_i,
  output logic [DATA_WIDTH-1:0] bc_data_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  fwd_count_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CPU_COUNT-1:0]  done_q, done_d;
  logic [CNT_WIDTH-1:0]  fwd_q, fwd_d;
  logic                  err_q, err_d;

  logic                  occ;
  logic                  push;
  logic                  retire;
  logic                  to_head;
  logic [CPU_COUNT-1:0]  acc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: occupancy moves by push minus retire
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (push) state_d = ONE;
      end
      ONE: begin
        if (push && !retire) state_d = TWO;
        else if (!push && retire) state_d = EMPTY;
      end
      TWO: begin
        if (retire) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs: pop never looks at bc_ready_i
  always_comb begin
    occ        = (state_q != EMPTY);
    push       = !rst && !fifo_empty_i && (state_q != TWO);
    bc_valid_o = occ ? ~done_q : '0;
    acc        = bc_valid_o & bc_ready_i;
    retire     = occ && (&(done_q | acc));
    fifo_rd_o  = push;
    busy_o     = occ;
  end

  assign bc_data_o   = head_q;
  assign fwd_count_o = fwd_q;
  assign err_o       = err_q;

  // Datapath next values
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    to_head = (state_q == EMPTY) || (state_q == ONE && retire);
    if (retire && state_q == TWO) begin
      head_d = tail_q;
    end
    if (push) begin
      if (to_head) head_d = fifo_data_i;
      else         tail_d = fifo_data_i;
    end
    done_d = retire ? '0 : (done_q | acc);
    fwd_d  = fwd_q;
    if (retire && fwd_q != {CNT_WIDTH{1'b1}}) begin
      fwd_d = fwd_q + CNT_WIDTH'(1);
    end
    // a ready on an occupied, not-yet-accepted, non-valid lane is impossible
    err_d = err_q | (occ && |(bc_ready_i & ~bc_valid_o & ~done_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      done_q <= '0;
      fwd_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      done_q <= done_d;
      fwd_q  <= fwd_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_mesi_isc_fifo_bcast_reader.sv
// Bench for mesi_isc_fifo_bcast_reader: queue-based FIFO and buffer model,
// second instance with a 4-bit counter for saturation.
module tb_mesi_isc_fifo_bcast_reader;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_rd_o, rd_s;
  logic [NC-1:0] bc_valid_o, valid_s;
  logic [NC-1:0] bc_ready_i;
  logic [DW-1:0] bc_data_o, data_s;
  logic          busy_o, busy_s;
  logic          err_o, err_s;
  logic [CW-1:0] fwd_count_o;
  logic [3:0]    fwd_s;

  mesi_isc_fifo_bcast_reader #(
    .DATA_WIDTH(DW), .CPU_COUNT(NC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_rd_o(fifo_rd_o), .bc_valid_o(bc_valid_o),
    .bc_ready_i(bc_ready_i), .bc_data_o(bc_data_o),
    .busy_o(busy_o), .fwd_count_o(fwd_count_o), .err_o(err_o)
  );

  mesi_isc_fifo_bcast_reader #(
    .DATA_WIDTH(DW), .CPU_COUNT(NC), .CNT_WIDTH(4)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_rd_o(rd_s), .bc_valid_o(valid_s),
    .bc_ready_i(bc_ready_i), .bc_data_o(data_s),
    .busy_o(busy_s), .fwd_count_o(fwd_s), .err_o(err_s)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // FIFO contents, buffered entries, per-target accepted flags
  logic [DW-1:0] fq[$];
  logic [DW-1:0] mb[$];
  logic [NC-1:0] mdone;
  int            mfwd;

  logic          e_rd;
  logic [NC-1:0] e_valid;
  logic          e_busy;
  logic [CW-1:0] e_fwd;
  logic [3:0]    e_fwd4;

  function automatic void drive_fifo();
    fifo_empty_i = (fq.size() == 0);
    fifo_data_i  = (fq.size() != 0) ? fq[0] : DW'($urandom);
  endfunction

  function automatic void model_reset();
    mb.delete();
    mdone = '0;
    mfwd  = 0;
  endfunction

  function automatic logic [33:0] exp_vec();
    return {e_rd, e_valid, e_busy, 1'b0, e_fwd,
            e_fwd4, e_rd, e_valid, e_busy, 1'b0};
  endfunction

  function automatic logic [33:0] obs_vec();
    return {fifo_rd_o, bc_valid_o, busy_o, err_o, fwd_count_o,
            fwd_s, rd_s, valid_s, busy_s, err_s};
  endfunction

  task automatic sample();
    @(negedge clk);
    e_rd    = (fq.size() > 0) && (mb.size() < 2);
    e_valid = (mb.size() > 0) ? ~mdone : '0;
    e_busy  = (mb.size() > 0);
    e_fwd   = (mfwd > 65535) ? 16'hFFFF : CW'(mfwd);
    e_fwd4  = (mfwd > 15) ? 4'd15 : 4'(mfwd);
  endtask

  task automatic advance();
    logic [NC-1:0] acc;
    acc = e_valid & bc_ready_i;
    if (mb.size() > 0 && (mdone | acc) == '1) begin
      void'(mb.pop_front());
      mdone = '0;
      mfwd++;
    end else begin
      mdone = mdone | acc;
    end
    if (e_rd) mb.push_back(fq.pop_front());
    @(posedge clk);
    #1;
    drive_fifo();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bc_ready_i = '1;
    fq.push_back(32'h1234_5678);
    drive_fifo();
    #2;
    total++;
    if ({fifo_rd_o, bc_valid_o, busy_o, err_o} !== 7'b0 ||
        bc_data_o !== '0 || fwd_count_o !== '0) begin
      $display("FAIL reset: rd=%b v=%b busy=%b err=%b d=%h fwd=%0d req all 0",
               fifo_rd_o, bc_valid_o, busy_o, err_o, bc_data_o, fwd_count_o);
    end else passed++;
    @(posedge clk);
    #1;
    fq.delete();
    drive_fifo();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    fq.push_back(32'hA5A5_0001);
    bc_ready_i = 4'b1111;
    drive_fifo();
    for (int c = 0; c < 3; c++) begin
      sample();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL single c%0d: got %h req %h", c, obs_vec(), exp_vec());
      else passed++;
      if (c == 1) begin
        total++;
        if (bc_valid_o !== 4'b1111 || bc_data_o !== 32'hA5A5_0001)
          $display("FAIL single_data: v=%b d=%h req 1111 a5a50001",
                   bc_valid_o, bc_data_o);
        else passed++;
      end
      advance();
    end
    total++;
    if (fwd_count_o !== 16'd1 || bc_valid_o !== '0)
      $display("FAIL single_end: fwd=%0d v=%b req 1 0000",
               fwd_count_o, bc_valid_o);
    else passed++;
  endtask

  task automatic test_staggered();
    logic [NC-1:0] rdy_t[3] = '{4'b0001, 4'b0100, 4'b1010};
    logic [NC-1:0] exp_t[4] = '{4'b1111, 4'b1110, 4'b1010, 4'b0000};
    logic [CW-1:0] f0;
    f0 = fwd_count_o;
    fq.push_back(32'hC0DE_0002);
    bc_ready_i = '0;
    drive_fifo();
    sample();
    advance();
    for (int c = 0; c < 4; c++) begin
      bc_ready_i = (c < 3) ? rdy_t[c] : 4'b0000;
      sample();
      total++;
      if (bc_valid_o !== exp_t[c] || obs_vec() !== exp_vec())
        $display("FAIL stagger c%0d: v=%b req %b vec %h req %h",
                 c, bc_valid_o, exp_t[c], obs_vec(), exp_vec());
      else passed++;
      advance();
    end
    total++;
    if (fwd_count_o !== f0 + 16'd1)
      $display("FAIL stagger_fwd: got %0d req %0d", fwd_count_o, f0 + 1);
    else passed++;
  endtask

  task automatic test_backpressure();
    int            pops;
    int            seen;
    logic [CW-1:0] f0;
    f0 = fwd_count_o;
    pops = 0;
    seen = 0;
    for (int k = 0; k < 5; k++) fq.push_back(32'h10 + 32'(k));
    bc_ready_i = '0;
    drive_fifo();
    for (int c = 0; c < 5; c++) begin
      sample();
      if (fifo_rd_o === 1'b1) pops++;
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL bp_hold c%0d: got %h req %h", c, obs_vec(), exp_vec());
      else passed++;
      advance();
    end
    total++;
    if (pops != 2 || busy_o !== 1'b1 || fifo_rd_o !== 1'b0)
      $display("FAIL bp_pops: pops=%0d busy=%b rd=%b req 2 1 0",
               pops, busy_o, fifo_rd_o);
    else passed++;
    bc_ready_i = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      sample();
      if (bc_valid_o === 4'b1111) begin
        total++;
        if (seen != c || bc_data_o !== 32'h10 + 32'(seen))
          $display("FAIL bp_order c%0d: d=%h req %h", c, bc_data_o,
                   32'h10 + 32'(seen));
        else passed++;
        seen++;
      end
      advance();
    end
    total++;
    if (seen != 5 || fwd_count_o !== f0 + 16'd5)
      $display("FAIL bp_drain: seen=%0d fwd=%0d req 5 %0d",
               seen, fwd_count_o, f0 + 5);
    else passed++;
  endtask

  task automatic test_streaming();
    logic [DW-1:0] ref_q[$];
    int            run;
    int            best;
    run = 0;
    best = 0;
    for (int k = 0; k < 8; k++) begin
      fq.push_back(DW'($urandom));
      ref_q.push_back(fq[k]);
    end
    bc_ready_i = 4'b1111;
    drive_fifo();
    for (int c = 0; c < 11; c++) begin
      sample();
      if (bc_valid_o === 4'b1111) begin
        run++;
        total++;
        if (ref_q.size() == 0 || bc_data_o !== ref_q[0])
          $display("FAIL stream_data c%0d: got %h", c, bc_data_o);
        else passed++;
        if (ref_q.size() != 0) void'(ref_q.pop_front());
      end else begin
        run = 0;
      end
      if (run > best) best = run;
      advance();
    end
    total++;
    if (best != 8)
      $display("FAIL stream_run: got %0d req 8", best);
    else passed++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 6) fq.push_back(DW'($urandom));
      bc_ready_i = NC'($urandom);
      drive_fifo();
      sample();
      total++;
      if (obs_vec() !== exp_vec() ||
          (mb.size() > 0 && (bc_data_o !== mb[0] || data_s !== mb[0]))) begin
        if (errs < 10)
          $display("FAIL random c%0d: got %h/%h req %h/%h", c, obs_vec(),
                   bc_data_o, exp_vec(), (mb.size() > 0) ? mb[0] : '0);
        errs++;
      end else passed++;
      advance();
    end
    bc_ready_i = '1;
    for (int c = 0; c < 20 && (fq.size() + mb.size()) > 0; c++) begin
      sample();
      advance();
    end
    total++;
    if (fq.size() + mb.size() != 0 || busy_o !== 1'b0)
      $display("FAIL random_drain: busy=%b left=%0d req 0",
               busy_o, fq.size() + mb.size());
    else passed++;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 20; k++) fq.push_back(32'h5A00 + 32'(k));
    bc_ready_i = '1;
    drive_fifo();
    for (int c = 0; c < 24; c++) begin
      sample();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL sat c%0d: got %h req %h", c, obs_vec(), exp_vec());
      else passed++;
      advance();
    end
    total++;
    if (fwd_s !== 4'd15 || fwd_count_o !== 16'd20)
      $display("FAIL sat_end: fwd4=%0d fwd16=%0d req 15 20",
               fwd_s, fwd_count_o);
    else passed++;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) fq.push_back(32'hBEEF_0000 + 32'(k));
    bc_ready_i = 4'b0001;
    drive_fifo();
    for (int c = 0; c < 3; c++) begin
      sample();
      advance();
    end
    total++;
    if (busy_o !== 1'b1 || bc_valid_o !== 4'b1110 || fifo_rd_o !== 1'b0)
      $display("FAIL rmid_pre: busy=%b v=%b rd=%b req 1 1110 0",
               busy_o, bc_valid_o, fifo_rd_o);
    else passed++;
    bc_ready_i = '0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bc_valid_o !== '0 || busy_o !== 1'b0 || fwd_count_o !== '0 ||
        fifo_rd_o !== 1'b0)
      $display("FAIL rmid_async: v=%b busy=%b fwd=%0d rd=%b req 0",
               bc_valid_o, busy_o, fwd_count_o, fifo_rd_o);
    else passed++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (fifo_rd_o !== 1'b0 || bc_valid_o !== '0)
        $display("FAIL rmid_hold c%0d: rd=%b v=%b req 0", c, fifo_rd_o,
                 bc_valid_o);
      else passed++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      sample();
      total++;
      if (obs_vec() !== exp_vec() ||
          (mb.size() > 0 && bc_data_o !== mb[0]))
        $display("FAIL rmid_post c%0d: got %h req %h", c, obs_vec(),
                 exp_vec());
      else passed++;
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    bc_ready_i = '0;
    fq.delete();
    model_reset();
    drive_fifo();
    test_reset();
    test_single();
    test_staggered();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
